// File: rtl/wb_ctrl_multi_if.sv
// Writeback bus between the execute lanes and the writeback controller.
// Carries the recovery request, per-lane writeback packets coming in, and
// the bypass, active-list completion and control-resolution results going out.
//   slave  : the writeback controller (consumes packets, drives results)
//   master : the producer/observer side (drives packets, reads results)
interface wb_ctrl_multi_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 7,
  parameter int SEQ_W  = 8,
  parameter int AL_W   = 7,
  parameter int PC_W   = 32,
  parameter int FLAG_W = 8
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic                               recoverFlag_i;
  logic [SEQ_W-1:0]                   recoverSeqNo_i;
  logic [LANES-1:0]                   wbValid_i;
  logic [LANES-1:0][SEQ_W-1:0]        wbSeqNo_i;
  logic [LANES-1:0][AL_W-1:0]         wbAlID_i;
  logic [LANES-1:0][TAG_W-1:0]        wbPhyDest_i;
  logic [LANES-1:0][DATA_W-1:0]       wbData_i;
  logic [LANES-1:0][FLAG_W-1:0]       wbFlags_i;
  logic [LANES-1:0][PC_W-1:0]         wbPC_i;
  logic [LANES-1:0][PC_W-1:0]         wbNextPC_i;
  logic [LANES-1:0]                   wbIsCtrl_i;
  logic [LANES-1:0]                   wbCtrlDir_i;

  logic [LANES-1:0]                   bypassValid_o;
  logic [LANES-1:0][TAG_W-1:0]        bypassTag_o;
  logic [LANES-1:0][DATA_W-1:0]       bypassData_o;
  logic [LANES-1:0]                   ctrlValid_o;
  logic [LANES-1:0][SEQ_W-1:0]        ctrlSeqNo_o;
  logic [LANES-1:0][AL_W-1:0]         ctrlAlID_o;
  logic [LANES-1:0][FLAG_W-1:0]       ctrlFlags_o;
  logic [LANES-1:0][PC_W-1:0]         ctrlNextPC_o;
  logic [LANES-1:0]                   ctrlDir_o;
  logic                               exeCtrlValid_o;
  logic [PC_W-1:0]                    exeCtrlPC_o;
  logic [PC_W-1:0]                    exeCtrlNPC_o;
  logic                               exeCtrlDir_o;
  logic [LANE_W-1:0]                  exeCtrlLane_o;
  logic [3:0]                         wbCount_o;
  logic [31:0]                        wbTotal_o;

  modport slave (
    input  recoverFlag_i, recoverSeqNo_i, wbValid_i, wbSeqNo_i, wbAlID_i,
           wbPhyDest_i, wbData_i, wbFlags_i, wbPC_i, wbNextPC_i,
           wbIsCtrl_i, wbCtrlDir_i,
    output bypassValid_o, bypassTag_o, bypassData_o, ctrlValid_o,
           ctrlSeqNo_o, ctrlAlID_o, ctrlFlags_o, ctrlNextPC_o, ctrlDir_o,
           exeCtrlValid_o, exeCtrlPC_o, exeCtrlNPC_o, exeCtrlDir_o,
           exeCtrlLane_o, wbCount_o, wbTotal_o
  );

  modport master (
    output recoverFlag_i, recoverSeqNo_i, wbValid_i, wbSeqNo_i, wbAlID_i,
           wbPhyDest_i, wbData_i, wbFlags_i, wbPC_i, wbNextPC_i,
           wbIsCtrl_i, wbCtrlDir_i,
    input  bypassValid_o, bypassTag_o, bypassData_o, ctrlValid_o,
           ctrlSeqNo_o, ctrlAlID_o, ctrlFlags_o, ctrlNextPC_o, ctrlDir_o,
           exeCtrlValid_o, exeCtrlPC_o, exeCtrlNPC_o, exeCtrlDir_o,
           exeCtrlLane_o, wbCount_o, wbTotal_o
  );
endinterface

// File: rtl/wb_ctrl_multi.sv
// Multi-lane writeback controller.
// Each lane is a DEPTH-stage shift pipeline; the final stage drives the
// bypass network, the active-list completion packet and, for the oldest
// resolved control instruction across lanes, the execute redirect info.
// A recovery squashes in-flight entries younger than the recovery seqNo
// (SELECTIVE=1) or everything (SELECTIVE=0), effective at the clock edge.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high; clears all stages and the running total
//   bus   : wb_ctrl_multi_if.slave (writeback packets in, results out)
module wb_ctrl_multi #(
  parameter int LANES     = 4,
  parameter int DEPTH     = 1,
  parameter int SELECTIVE = 1,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 7,
  parameter int SEQ_W     = 8,
  parameter int AL_W      = 7,
  parameter int PC_W      = 32,
  parameter int FLAG_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  wb_ctrl_multi_if.slave   bus
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [AL_W-1:0]   al;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flags;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   npc;
    logic              is_ctrl;
    logic              dir;
  } ent_t;

  // a is younger than b when the modular distance is nonzero and "positive"
  function automatic logic younger(input logic [SEQ_W-1:0] a,
                                   input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] d;
    d = a - b;
    return (d != '0) && !d[SEQ_W-1];
  endfunction

  function automatic logic squash(input logic rec,
                                  input logic [SEQ_W-1:0] rseq,
                                  input logic [SEQ_W-1:0] s);
    return rec && ((SELECTIVE == 0) || younger(s, rseq));
  endfunction

  ent_t             in_ent [LANES];
  logic [LANES-1:0] vld_q  [DEPTH];
  logic [LANES-1:0] vld_d  [DEPTH];
  ent_t             ent_q  [DEPTH][LANES];
  ent_t             ent_d  [DEPTH][LANES];
  logic [31:0]      total_q, total_d;
  logic [3:0]       cnt;
  logic             sel_found;
  logic [LANE_W-1:0] sel_lane;
  logic [SEQ_W-1:0] sel_seq;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      in_ent[l].seq     = bus.wbSeqNo_i[l];
      in_ent[l].al      = bus.wbAlID_i[l];
      in_ent[l].tag     = bus.wbPhyDest_i[l];
      in_ent[l].data    = bus.wbData_i[l];
      in_ent[l].flags   = bus.wbFlags_i[l];
      in_ent[l].pc      = bus.wbPC_i[l];
      in_ent[l].npc     = bus.wbNextPC_i[l];
      in_ent[l].is_ctrl = bus.wbIsCtrl_i[l];
      in_ent[l].dir     = bus.wbCtrlDir_i[l];
    end
  end

  // Stage advance: entries move one stage per cycle, recovery clears valids
  // of both captured inputs and entries moving between stages.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      vld_d[0][l] = bus.wbValid_i[l] &
                    ~squash(bus.recoverFlag_i, bus.recoverSeqNo_i, in_ent[l].seq);
      ent_d[0][l] = in_ent[l];
    end
    for (int s = 1; s < DEPTH; s++) begin
      for (int l = 0; l < LANES; l++) begin
        vld_d[s][l] = vld_q[s-1][l] &
                      ~squash(bus.recoverFlag_i, bus.recoverSeqNo_i, ent_q[s-1][l].seq);
        ent_d[s][l] = ent_q[s-1][l];
      end
    end
  end

  // Final stage: per-lane outputs and writeback count
  always_comb begin
    cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.bypassValid_o[l] = vld_q[DEPTH-1][l] & ent_q[DEPTH-1][l].flags[4];
      bus.bypassTag_o[l]   = ent_q[DEPTH-1][l].tag;
      bus.bypassData_o[l]  = ent_q[DEPTH-1][l].data;
      bus.ctrlValid_o[l]   = vld_q[DEPTH-1][l];
      bus.ctrlSeqNo_o[l]   = ent_q[DEPTH-1][l].seq;
      bus.ctrlAlID_o[l]    = ent_q[DEPTH-1][l].al;
      bus.ctrlFlags_o[l]   = ent_q[DEPTH-1][l].flags;
      bus.ctrlNextPC_o[l]  = ent_q[DEPTH-1][l].npc;
      bus.ctrlDir_o[l]     = ent_q[DEPTH-1][l].dir;
      cnt = cnt + 4'(vld_q[DEPTH-1][l]);
    end
    total_d = total_q + 32'(cnt);
  end

  // Oldest control instruction wins; a strict-older test keeps ties on the
  // lowest lane because lanes are scanned upward.
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = '0;
    sel_seq   = '0;
    for (int l = 0; l < LANES; l++) begin
      if (vld_q[DEPTH-1][l] && ent_q[DEPTH-1][l].is_ctrl &&
          (!sel_found || younger(sel_seq, ent_q[DEPTH-1][l].seq))) begin
        sel_found = 1'b1;
        sel_lane  = LANE_W'(l);
        sel_seq   = ent_q[DEPTH-1][l].seq;
      end
    end
  end

  assign bus.exeCtrlValid_o = sel_found;
  assign bus.exeCtrlLane_o  = sel_lane;
  assign bus.exeCtrlPC_o    = sel_found ? ent_q[DEPTH-1][sel_lane].pc  : '0;
  assign bus.exeCtrlNPC_o   = sel_found ? ent_q[DEPTH-1][sel_lane].npc : '0;
  assign bus.exeCtrlDir_o   = sel_found & ent_q[DEPTH-1][sel_lane].dir;
  assign bus.wbCount_o      = cnt;
  assign bus.wbTotal_o      = total_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        vld_q[s] <= '0;
        for (int l = 0; l < LANES; l++) ent_q[s][l] <= '0;
      end
      total_q <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        vld_q[s] <= vld_d[s];
        for (int l = 0; l < LANES; l++) ent_q[s][l] <= ent_d[s][l];
      end
      total_q <= total_d;
    end
  end
endmodule

// File: tb/tb_wb_ctrl_multi.sv
// Directed bench: three controllers share one stimulus stream.
//   u_a : DEPTH=2, SELECTIVE=1   u_b : DEPTH=3, SELECTIVE=1   u_c : DEPTH=3, SELECTIVE=0
module tb_wb_ctrl_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic rec;
  logic [7:0] rec_seq;
  logic [3:0] v, isc, dir;
  logic [3:0][7:0]  seq, flags;
  logic [3:0][6:0]  al, tag;
  logic [3:0][31:0] data, pc, npc;

  int errors = 0;
  int checks = 0;

  wb_ctrl_multi_if ba();
  wb_ctrl_multi_if bb();
  wb_ctrl_multi_if bc();

  assign ba.recoverFlag_i = rec;   assign bb.recoverFlag_i = rec;   assign bc.recoverFlag_i = rec;
  assign ba.recoverSeqNo_i = rec_seq; assign bb.recoverSeqNo_i = rec_seq; assign bc.recoverSeqNo_i = rec_seq;
  assign ba.wbValid_i = v;         assign bb.wbValid_i = v;         assign bc.wbValid_i = v;
  assign ba.wbSeqNo_i = seq;       assign bb.wbSeqNo_i = seq;       assign bc.wbSeqNo_i = seq;
  assign ba.wbAlID_i = al;         assign bb.wbAlID_i = al;         assign bc.wbAlID_i = al;
  assign ba.wbPhyDest_i = tag;     assign bb.wbPhyDest_i = tag;     assign bc.wbPhyDest_i = tag;
  assign ba.wbData_i = data;       assign bb.wbData_i = data;       assign bc.wbData_i = data;
  assign ba.wbFlags_i = flags;     assign bb.wbFlags_i = flags;     assign bc.wbFlags_i = flags;
  assign ba.wbPC_i = pc;           assign bb.wbPC_i = pc;           assign bc.wbPC_i = pc;
  assign ba.wbNextPC_i = npc;      assign bb.wbNextPC_i = npc;      assign bc.wbNextPC_i = npc;
  assign ba.wbIsCtrl_i = isc;      assign bb.wbIsCtrl_i = isc;      assign bc.wbIsCtrl_i = isc;
  assign ba.wbCtrlDir_i = dir;     assign bb.wbCtrlDir_i = dir;     assign bc.wbCtrlDir_i = dir;

  wb_ctrl_multi #(.DEPTH(2), .SELECTIVE(1)) u_a (.clk(clk), .reset(reset), .bus(ba));
  wb_ctrl_multi #(.DEPTH(3), .SELECTIVE(1)) u_b (.clk(clk), .reset(reset), .bus(bb));
  wb_ctrl_multi #(.DEPTH(3), .SELECTIVE(0)) u_c (.clk(clk), .reset(reset), .bus(bc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    rec = 0; rec_seq = 0; v = 0; isc = 0; dir = 0;
    seq = '0; flags = '0; al = '0; tag = '0; data = '0; pc = '0; npc = '0;
  endtask

  task automatic do_reset();
    reset = 1; clr_in(); step(); step(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; rec = 1; v = 4'hF; isc = 4'hF; flags = {4{8'h10}}; seq = {8'd1, 8'd2, 8'd3, 8'd4};
    step(); step();
    checks++; if (ba.bypassValid_o !== 4'b0) begin errors++; $display("FAIL rst_bypv got %b exp 0", ba.bypassValid_o); end
    checks++; if (ba.ctrlValid_o !== 4'b0) begin errors++; $display("FAIL rst_ctrlv got %b exp 0", ba.ctrlValid_o); end
    checks++; if (ba.wbCount_o !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", ba.wbCount_o); end
    checks++; if (ba.wbTotal_o !== 32'd0) begin errors++; $display("FAIL rst_total got %0d exp 0", ba.wbTotal_o); end
    checks++; if (ba.exeCtrlValid_o !== 1'b0) begin errors++; $display("FAIL rst_exev got %b exp 0", ba.exeCtrlValid_o); end
    checks++; if (ba.exeCtrlLane_o !== 2'd0) begin errors++; $display("FAIL rst_exelane got %0d exp 0", ba.exeCtrlLane_o); end
    checks++; if (bb.ctrlValid_o !== 4'b0) begin errors++; $display("FAIL rst_b_ctrlv got %b exp 0", bb.ctrlValid_o); end
    clr_in(); step(); reset = 0;
  endtask

  task automatic test_latency();
    do_reset();
    v = 4'b0011;
    seq[1] = 8'd5; tag[1] = 7'h12; data[1] = 32'hDEADBEEF; flags[1] = 8'h10; al[1] = 7'h33;
    seq[0] = 8'd6; flags[0] = 8'h00;
    step();
    checks++; if (ba.ctrlValid_o !== 4'b0) begin errors++; $display("FAIL lat_early got %b exp 0", ba.ctrlValid_o); end
    clr_in(); step();
    checks++; if (ba.bypassValid_o !== 4'b0010) begin errors++; $display("FAIL lat_bypv got %b exp 0010", ba.bypassValid_o); end
    checks++; if (ba.bypassTag_o[1] !== 7'h12) begin errors++; $display("FAIL lat_tag got %h exp 12", ba.bypassTag_o[1]); end
    checks++; if (ba.bypassData_o[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_data got %h exp deadbeef", ba.bypassData_o[1]); end
    checks++; if (ba.ctrlValid_o !== 4'b0011) begin errors++; $display("FAIL lat_ctrlv got %b exp 0011", ba.ctrlValid_o); end
    checks++; if (ba.ctrlSeqNo_o[1] !== 8'd5) begin errors++; $display("FAIL lat_seq got %0d exp 5", ba.ctrlSeqNo_o[1]); end
    checks++; if (ba.ctrlAlID_o[1] !== 7'h33) begin errors++; $display("FAIL lat_al got %h exp 33", ba.ctrlAlID_o[1]); end
    checks++; if (ba.ctrlFlags_o[1] !== 8'h10) begin errors++; $display("FAIL lat_flags got %h exp 10", ba.ctrlFlags_o[1]); end
    checks++; if (ba.wbCount_o !== 4'd2) begin errors++; $display("FAIL lat_count got %0d exp 2", ba.wbCount_o); end
    step();
    checks++; if (ba.ctrlValid_o !== 4'b0 || ba.bypassValid_o !== 4'b0) begin errors++; $display("FAIL lat_after got %b/%b exp 0/0", ba.ctrlValid_o, ba.bypassValid_o); end
    checks++; if (ba.wbTotal_o !== 32'd2) begin errors++; $display("FAIL lat_total got %0d exp 2", ba.wbTotal_o); end
    checks++; if (bb.ctrlValid_o !== 4'b0011) begin errors++; $display("FAIL lat_d3_ctrlv got %b exp 0011", bb.ctrlValid_o); end
  endtask

  task automatic test_squash();
    do_reset();
    v = 4'b0001; seq[0] = 8'd10; step();
    seq[0] = 8'd12; step();
    seq[0] = 8'd14; step();
    v = 4'b0110; seq[0] = 8'd0; seq[1] = 8'd13; seq[2] = 8'd11;
    rec = 1; rec_seq = 8'd12;
    #1;
    checks++; if (bb.ctrlValid_o !== 4'b0001 || bb.ctrlSeqNo_o[0] !== 8'd10) begin errors++; $display("FAIL sq_head got %b/%0d exp 0001/10", bb.ctrlValid_o, bb.ctrlSeqNo_o[0]); end
    checks++; if (bc.ctrlValid_o !== 4'b0001) begin errors++; $display("FAIL fl_head got %b exp 0001", bc.ctrlValid_o); end
    step(); clr_in();
    checks++; if (bb.ctrlValid_o !== 4'b0001 || bb.ctrlSeqNo_o[0] !== 8'd12) begin errors++; $display("FAIL sq_keep12 got %b/%0d exp 0001/12", bb.ctrlValid_o, bb.ctrlSeqNo_o[0]); end
    checks++; if (bc.ctrlValid_o !== 4'b0) begin errors++; $display("FAIL fl_clear got %b exp 0", bc.ctrlValid_o); end
    step();
    checks++; if (bb.ctrlValid_o !== 4'b0) begin errors++; $display("FAIL sq_no14 got %b exp 0", bb.ctrlValid_o); end
    step();
    checks++; if (bb.ctrlValid_o !== 4'b0100 || bb.ctrlSeqNo_o[2] !== 8'd11) begin errors++; $display("FAIL sq_in11 got %b/%0d exp 0100/11", bb.ctrlValid_o, bb.ctrlSeqNo_o[2]); end
    checks++; if (bc.ctrlValid_o !== 4'b0) begin errors++; $display("FAIL fl_drop got %b exp 0", bc.ctrlValid_o); end
    step();
    checks++; if (bb.ctrlValid_o !== 4'b0) begin errors++; $display("FAIL sq_tail got %b exp 0", bb.ctrlValid_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    v = 4'b0011; seq[0] = 8'd250; seq[1] = 8'd3; step();
    clr_in(); rec = 1; rec_seq = 8'd252; step();
    clr_in();
    checks++; if (ba.ctrlValid_o !== 4'b0001 || ba.ctrlSeqNo_o[0] !== 8'd250) begin errors++; $display("FAIL wrap_a got %b/%0d exp 0001/250", ba.ctrlValid_o, ba.ctrlSeqNo_o[0]); end
    step();
    checks++; if (bb.ctrlValid_o !== 4'b0001) begin errors++; $display("FAIL wrap_b got %b exp 0001", bb.ctrlValid_o); end
  endtask

  task automatic test_ctrl_sel();
    do_reset();
    v = 4'b0111; isc = 4'b0101; dir = 4'b0100;
    seq[0] = 8'd7; seq[1] = 8'd1; seq[2] = 8'd4;
    pc[0] = 32'h10; pc[2] = 32'h20; npc[0] = 32'h100; npc[2] = 32'h200;
    step(); clr_in(); step();
    checks++; if (ba.exeCtrlValid_o !== 1'b1 || ba.exeCtrlLane_o !== 2'd2) begin errors++; $display("FAIL sel_lane got %b/%0d exp 1/2", ba.exeCtrlValid_o, ba.exeCtrlLane_o); end
    checks++; if (ba.exeCtrlNPC_o !== 32'h200 || ba.exeCtrlPC_o !== 32'h20) begin errors++; $display("FAIL sel_pc got %h/%h exp 200/20", ba.exeCtrlNPC_o, ba.exeCtrlPC_o); end
    checks++; if (ba.exeCtrlDir_o !== 1'b1) begin errors++; $display("FAIL sel_dir got %b exp 1", ba.exeCtrlDir_o); end
    v = 4'b1101; isc = 4'b1101; seq[0] = 8'd9; seq[2] = 8'd9; seq[3] = 8'd9;
    npc[0] = 32'h100; npc[2] = 32'h200; npc[3] = 32'h300; dir = 4'b1100;
    step(); clr_in(); step();
    checks++; if (ba.exeCtrlLane_o !== 2'd0 || ba.exeCtrlNPC_o !== 32'h100) begin errors++; $display("FAIL sel_tie got %0d/%h exp 0/100", ba.exeCtrlLane_o, ba.exeCtrlNPC_o); end
    checks++; if (ba.exeCtrlDir_o !== 1'b0) begin errors++; $display("FAIL sel_tie_dir got %b exp 0", ba.exeCtrlDir_o); end
    v = 4'b1001; isc = 4'b1001; seq[0] = 8'd2; seq[3] = 8'd254; npc[0] = 32'h100; npc[3] = 32'h300;
    step(); clr_in(); step();
    checks++; if (ba.exeCtrlLane_o !== 2'd3 || ba.exeCtrlNPC_o !== 32'h300) begin errors++; $display("FAIL sel_wrap got %0d/%h exp 3/300", ba.exeCtrlLane_o, ba.exeCtrlNPC_o); end
    v = 4'b0011; isc = 4'b0000; seq[0] = 8'd1; seq[1] = 8'd2;
    step(); clr_in(); step();
    checks++; if (ba.exeCtrlValid_o !== 1'b0 || ba.exeCtrlLane_o !== 2'd0) begin errors++; $display("FAIL sel_none got %b/%0d exp 0/0", ba.exeCtrlValid_o, ba.exeCtrlLane_o); end
  endtask

  task automatic test_count();
    do_reset();
    v = 4'hF; step(); step();
    checks++; if (ba.wbCount_o !== 4'd4 || ba.wbTotal_o !== 32'd0) begin errors++; $display("FAIL cnt_c1 got %0d/%0d exp 4/0", ba.wbCount_o, ba.wbTotal_o); end
    step();
    checks++; if (ba.wbCount_o !== 4'd4 || ba.wbTotal_o !== 32'd4) begin errors++; $display("FAIL cnt_c2 got %0d/%0d exp 4/4", ba.wbCount_o, ba.wbTotal_o); end
    clr_in(); step();
    checks++; if (ba.wbCount_o !== 4'd4 || ba.wbTotal_o !== 32'd8) begin errors++; $display("FAIL cnt_c3 got %0d/%0d exp 4/8", ba.wbCount_o, ba.wbTotal_o); end
    step();
    checks++; if (ba.wbCount_o !== 4'd0 || ba.wbTotal_o !== 32'd12) begin errors++; $display("FAIL cnt_total got %0d/%0d exp 0/12", ba.wbCount_o, ba.wbTotal_o); end
    reset = 1; rec = 1; rec_seq = 8'd0; v = 4'hF; step();
    checks++; if (ba.wbTotal_o !== 32'd0 || ba.wbCount_o !== 4'd0) begin errors++; $display("FAIL cnt_rst got %0d/%0d exp 0/0", ba.wbTotal_o, ba.wbCount_o); end
    step();
    checks++; if (ba.ctrlValid_o !== 4'b0 || bb.ctrlValid_o !== 4'b0 || ba.wbTotal_o !== 32'd0) begin errors++; $display("FAIL cnt_rst_hold got %b/%b/%0d exp 0/0/0", ba.ctrlValid_o, bb.ctrlValid_o, ba.wbTotal_o); end
    clr_in(); step(); reset = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      v = 4'b1000; seq[3] = 8'(20 + i); data[3] = 32'(i);
      step();
      if (i >= 1) begin
        checks++; if (ba.ctrlValid_o !== 4'b1000 || ba.ctrlSeqNo_o[3] !== 8'(19 + i)) begin errors++; $display("FAIL b2b_%0d got %b/%0d exp 1000/%0d", i, ba.ctrlValid_o, ba.ctrlSeqNo_o[3], 19 + i); end
      end
    end
    clr_in(); step();
    checks++; if (ba.ctrlSeqNo_o[3] !== 8'd25 || ba.bypassData_o[3] !== 32'd5) begin errors++; $display("FAIL b2b_last got %0d/%0d exp 25/5", ba.ctrlSeqNo_o[3], ba.bypassData_o[3]); end
    step();
    checks++; if (ba.ctrlValid_o !== 4'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", ba.ctrlValid_o); end
  endtask

  initial begin
    reset = 1;
    clr_in();
    test_reset();
    test_latency();
    test_squash();
    test_wrap();
    test_ctrl_sel();
    test_count();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
